zxiznet_bus_ctrl: RTL and testbench
===================================

// Module: zxiznet_bus_ctrl
// PURPOSE
// - ZX-bus interface glue for the ZXiznet network/USB card: decodes Z80 I/O and memory cycles,
//   holds control registers, bridges zd<->bd for a W5300 Ethernet chip and an SL811 USB host.
// - Drives chip selects, resets, address lines, ROM-blocking and a combined Z80 interrupt.
// PARAMETERS
// - PORT_LO  8'hAB  low address byte shared by all card I/O ports
// PORTS
// - clk          in   1   system clock (Z80 clock domain)
// - rst          in   1   synchronous active-high reset
// - za           in   16  Z80 address
// - zd           inout 8  Z80 data; driven only during card I/O/window reads
// - ziorq_n, zmreq_n, zrd_n, zwr_n  in 1 each  Z80 strobes
// - zcsrom_n     in   1   host ROM chip select (0 = ROM area access)
// - ziorqge      out  1   1 = card claims current I/O read
// - zblkrom      out  1   1 = block host ROM (W5300 window active)
// - zint_n       out  1   open-drain interrupt: 0 or Z
// - bd           inout 8  card-side data bus
// - brd_n, bwr_n out  1   card-side strobes
// - w5300_rst_n, w5300_cs_n out 1; w5300_addr out 10; w5300_int_n in 1
// - sl811_rst_n, sl811_cs_n, sl811_ms_n, sl811_a0 out 1; sl811_intrq in 1
// - usb_power    in   1   USB VBUS status
// BEHAVIOUR
// - Ports (low byte PORT_LO): 83=RSTINT, 82=WCFG, 81=SLCFG, 80=SL_ADDR (a0=0), 7F=SL_DATA (a0=1).
// - RSTINT: b0 ~w5300_int_n (RO), b1 sl811_intrq (RO), b2 usb_power (RO), b3 0, b4 W5300 run,
//   b5 SL811 run, b6 W5300 int enable, b7 SL811 int enable. Reset: b7..b4 = 0.
// - w5300_rst_n = b4, sl811_rst_n = b5 (combinational from reg; both 0 after reset).
// - WCFG: b7 window enable, b3:0 window page; reset 8'h00. Reads return stored value.
// - SLCFG: b0 master; sl811_ms_n = ~b0; reset 8'h01; other bits read 0.
// - Register write: on first clk where ziorq_n=0 & zwr_n=0 & port hit (edge vs registered
//   previous strobe), latch zd; visible next cycle. Write held long = single write.
// - I/O read of any card port: zd driven combinationally, ziorqge=1 while ziorq_n=0 & zrd_n=0 & hit.
// - SL_ADDR/SL_DATA: sl811_cs_n=0 while ziorq_n=0 & hit; sl811_a0 per port;
//   brd_n=zrd_n, bwr_n=zwr_n; bd<=zd on write, zd<=bd on read.
// - Window: zmreq_n=0 & zcsrom_n=0 & WCFG.b7 & za[13:10]==page -> w5300_cs_n=0,
//   w5300_addr=za[9:0], bridge as above. zblkrom=1 whenever zcsrom_n=0 & WCFG.b7.
// - Outside any hit: cs_n=1, brd_n=bwr_n=1, bd and zd Z, w5300_addr=0.
// - zint_n=0 when (b6 & ~w5300_int_n) | (b7 & sl811_intrq), else Z.
// - Reset mid-cycle: registers return to defaults; bus bridging stays combinational.
// - Simultaneous I/O and memory strobes: I/O decode wins; window inactive.
// CONFIGURATION
// - ZXIZNET_ZINT_EN defined: interrupt logic as above.
// - Undefined: zint_n constant Z; RSTINT b7:b6 forced 0 (writes ignored).
// STRUCTURE
// - Package zxiznet_pkg: port high-byte constants, RSTINT bit indices, reset values.
// - Sub-module zxiznet_io_decode: port/window hit decode and write-edge strobe generation.
// - Top holds registers, data-bus muxes, tri-state drivers.
// TESTING
// - After rst: w5300_rst_n=0, sl811_rst_n=0; read #83AB -> b5:4=00, ziorqge=1 during read.
// - Write #83AB=8'h30 -> w5300_rst_n=1, sl811_rst_n=1; readback b5:4=11.
// - Write #80AB=8'h05 -> sl811_cs_n=0, a0=0, bwr_n=0, bd=8'h05; read #7FAB with bd=8'h5A -> zd=8'h5A, a0=1.
// - Write #82AB=8'h82; mem read za=16'h0B12, zcsrom_n=0 -> w5300_cs_n=0, w5300_addr=10'h312, zblkrom=1.
// - #83AB=8'h40, w5300_int_n=0 -> zint_n=0; clear b6 -> zint_n=Z.
// - Read #83AC (miss) -> ziorqge=0, zd Z, all cs_n=1.

Source files
------------

// File: rtl/zxiznet_pkg.sv
// Shared constants for the ZXiznet bus controller: I/O port high bytes,
// RSTINT bit layout, register reset values and the port decoder.
package zxiznet_pkg;

  localparam logic [7:0] PORT_HI_RSTINT  = 8'h83;
  localparam logic [7:0] PORT_HI_WCFG    = 8'h82;
  localparam logic [7:0] PORT_HI_SLCFG   = 8'h81;
  localparam logic [7:0] PORT_HI_SL_ADDR = 8'h80;
  localparam logic [7:0] PORT_HI_SL_DATA = 8'h7F;

  localparam int RSTINT_W5300_INT = 0;
  localparam int RSTINT_SL811_INT = 1;
  localparam int RSTINT_USB_PWR   = 2;
  localparam int RSTINT_W5300_RUN = 4;
  localparam int RSTINT_SL811_RUN = 5;
  localparam int RSTINT_W5300_IEN = 6;
  localparam int RSTINT_SL811_IEN = 7;

  // Writable upper nibble of RSTINT (b7..b4)
  localparam logic [3:0] RSTINT_CTRL_RST = 4'h0;
  localparam logic [7:0] WCFG_RST        = 8'h00;
  localparam logic       SLCFG_MS_RST    = 1'b1;

  typedef enum logic [2:0] {
    PORT_NONE,
    PORT_RSTINT,
    PORT_WCFG,
    PORT_SLCFG,
    PORT_SL_ADDR,
    PORT_SL_DATA
  } port_e;

  function automatic port_e decode_port(input logic [15:0] addr, input logic [7:0] lo);
    port_e p;
    p = PORT_NONE;
    if (addr[7:0] == lo) begin
      case (addr[15:8])
        PORT_HI_RSTINT:  p = PORT_RSTINT;
        PORT_HI_WCFG:    p = PORT_WCFG;
        PORT_HI_SLCFG:   p = PORT_SLCFG;
        PORT_HI_SL_ADDR: p = PORT_SL_ADDR;
        PORT_HI_SL_DATA: p = PORT_SL_DATA;
        default:         p = PORT_NONE;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/zxiznet_io_decode.sv
// Port and W5300 window hit decode, plus a single-cycle register write strobe
// taken on the leading edge of an I/O write to any card port.
module zxiznet_io_decode
  import zxiznet_pkg::*;
#(
  parameter logic [7:0] PORT_LO = 8'hAB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] za,
  input  logic        ziorq_n,
  input  logic        zmreq_n,
  input  logic        zwr_n,
  input  logic        zcsrom_n,
  input  logic        win_en,
  input  logic [3:0]  win_page,
  output port_e       io_port,
  output logic        sl_sel,
  output logic        win_sel,
  output logic        wr_stb
);

  logic wr_req_d;
  logic wr_req_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    io_port  = PORT_NONE;
    if (!ziorq_n) io_port = decode_port(za, PORT_LO);
    sl_sel   = (io_port == PORT_SL_ADDR) || (io_port == PORT_SL_DATA);
    // An I/O cycle always wins over a concurrent memory cycle.
    win_sel  = ziorq_n && !zmreq_n && !zcsrom_n && win_en && (za[13:10] == win_page);
    wr_req_d = (io_port != PORT_NONE) && !zwr_n;
    wr_stb   = wr_req_d && !wr_req_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) wr_req_q <= 1'b0;
    else     wr_req_q <= wr_req_d;
  end

endmodule

// File: rtl/zxiznet_bus_ctrl.sv
// ZX-bus glue for the ZXiznet card: control registers, W5300/SL811 bridging,
// data-bus muxes and tri-state drivers. Define ZXIZNET_ZINT_EN to enable the Z80 interrupt.
module zxiznet_bus_ctrl
  import zxiznet_pkg::*;
#(
  parameter logic [7:0] PORT_LO = 8'hAB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] za,
  inout  wire  [7:0]  zd,
  input  logic        ziorq_n,
  input  logic        zmreq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        zcsrom_n,
  output logic        ziorqge,
  output logic        zblkrom,
  output wire         zint_n,
  inout  wire  [7:0]  bd,
  output logic        brd_n,
  output logic        bwr_n,
  output logic        w5300_rst_n,
  output logic        w5300_cs_n,
  output logic [9:0]  w5300_addr,
  input  logic        w5300_int_n,
  output logic        sl811_rst_n,
  output logic        sl811_cs_n,
  output logic        sl811_ms_n,
  output logic        sl811_a0,
  input  logic        sl811_intrq,
  input  logic        usb_power
);

`ifdef ZXIZNET_ZINT_EN
  localparam logic [1:0] IEN_MASK = 2'b11;
`else
  localparam logic [1:0] IEN_MASK = 2'b00;
`endif

  port_e      io_port;
  logic       sl_sel;
  logic       win_sel;
  logic       wr_stb;

  logic [3:0] ctrl_d, ctrl_q;
  logic [7:0] wcfg_d, wcfg_q;
  logic       ms_d, ms_q;
  logic [7:0] rstint_rd;
  logic [7:0] zd_rd;
  logic       zd_oe;
  logic       bd_oe;
  logic       bridge;

  zxiznet_io_decode #(.PORT_LO(PORT_LO)) u_decode (
    .clk      (clk),
    .rst      (rst),
    .za       (za),
    .ziorq_n  (ziorq_n),
    .zmreq_n  (zmreq_n),
    .zwr_n    (zwr_n),
    .zcsrom_n (zcsrom_n),
    .win_en   (wcfg_q[7]),
    .win_page (wcfg_q[3:0]),
    .io_port  (io_port),
    .sl_sel   (sl_sel),
    .win_sel  (win_sel),
    .wr_stb   (wr_stb)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    wcfg_d = wcfg_q;
    ms_d   = ms_q;
    if (wr_stb) begin
      case (io_port)
        PORT_RSTINT: ctrl_d = {zd[RSTINT_SL811_IEN:RSTINT_W5300_IEN] & IEN_MASK,
                               zd[RSTINT_SL811_RUN:RSTINT_W5300_RUN]};
        PORT_WCFG:   wcfg_d = zd;
        PORT_SLCFG:  ms_d   = zd[0];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= RSTINT_CTRL_RST;
      wcfg_q <= WCFG_RST;
      ms_q   <= SLCFG_MS_RST;
    end else begin
      ctrl_q <= ctrl_d;
      wcfg_q <= wcfg_d;
      ms_q   <= ms_d;
    end
  end

  // Low nibble of RSTINT is live status, never stored.
  always_comb begin
    rstint_rd = {ctrl_q, 1'b0, usb_power, sl811_intrq, ~w5300_int_n};
    case (io_port)
      PORT_RSTINT: zd_rd = rstint_rd;
      PORT_WCFG:   zd_rd = wcfg_q;
      PORT_SLCFG:  zd_rd = {7'b0, ms_q};
      default:     zd_rd = bd;
    endcase
    ziorqge = (io_port != PORT_NONE) && !zrd_n;
    zd_oe   = ziorqge || (win_sel && !zrd_n);
    bridge  = sl_sel || win_sel;
    bd_oe   = bridge && !zwr_n;
  end

  assign zd = zd_oe ? zd_rd : 8'hzz;
  assign bd = bd_oe ? zd : 8'hzz;

  assign brd_n       = bridge ? zrd_n : 1'b1;
  assign bwr_n       = bridge ? zwr_n : 1'b1;
  assign zblkrom     = !zcsrom_n && wcfg_q[7];
  assign w5300_cs_n  = !win_sel;
  assign w5300_addr  = win_sel ? za[9:0] : 10'h000;
  assign w5300_rst_n = ctrl_q[0];
  assign sl811_rst_n = ctrl_q[1];
  assign sl811_cs_n  = !sl_sel;
  assign sl811_a0    = sl_sel && (io_port == PORT_SL_DATA);
  assign sl811_ms_n  = !ms_q;

`ifdef ZXIZNET_ZINT_EN
  logic irq;
  assign irq    = (ctrl_q[2] && !w5300_int_n) || (ctrl_q[3] && sl811_intrq);
  assign zint_n = irq ? 1'b0 : 1'bz;
`else
  assign zint_n = 1'bz;
`endif

endmodule

// File: tb/tb_zxiznet_bus_ctrl.sv
// Randomized bench for zxiznet_bus_ctrl against a behavioural model of the card;
// pull-ups on the shared buses make an undriven line read as all ones.
module tb_zxiznet_bus_ctrl;

  localparam logic [7:0] PORT_LO = 8'hAB;
`ifdef ZXIZNET_ZINT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] za;
  logic        ziorq_n, zmreq_n, zrd_n, zwr_n, zcsrom_n;
  logic        w5300_int_n, sl811_intrq, usb_power;
  logic        tb_zd_oe, tb_bd_oe;
  logic [7:0]  tb_zd, tb_bd;
  wire  [7:0]  zd, bd;
  wire         zint_n;
  logic        ziorqge, zblkrom, brd_n, bwr_n;
  logic        w5300_rst_n, w5300_cs_n, sl811_rst_n, sl811_cs_n, sl811_ms_n, sl811_a0;
  logic [9:0]  w5300_addr;

  pullup (zint_n);
  pullup (zd);
  pullup (bd);
  assign zd = tb_zd_oe ? tb_zd : 8'hzz;
  assign bd = tb_bd_oe ? tb_bd : 8'hzz;

  always #5 clk = ~clk;

  zxiznet_bus_ctrl #(.PORT_LO(PORT_LO)) dut (
    .clk(clk), .rst(rst), .za(za), .zd(zd),
    .ziorq_n(ziorq_n), .zmreq_n(zmreq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zcsrom_n(zcsrom_n),
    .ziorqge(ziorqge), .zblkrom(zblkrom), .zint_n(zint_n),
    .bd(bd), .brd_n(brd_n), .bwr_n(bwr_n),
    .w5300_rst_n(w5300_rst_n), .w5300_cs_n(w5300_cs_n), .w5300_addr(w5300_addr),
    .w5300_int_n(w5300_int_n),
    .sl811_rst_n(sl811_rst_n), .sl811_cs_n(sl811_cs_n), .sl811_ms_n(sl811_ms_n),
    .sl811_a0(sl811_a0), .sl811_intrq(sl811_intrq), .usb_power(usb_power)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model of the card's programmer-visible state.
  bit       m_run_w = 0, m_run_s = 0, m_ien_w = 0, m_ien_s = 0, m_ms = 1, m_prev_wr = 0;
  bit [7:0] m_wcfg = 8'h00;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_card_port(input logic [15:0] a);
    return a[7:0] == PORT_LO && a[15:8] inside {8'h83, 8'h82, 8'h81, 8'h80, 8'h7F};
  endfunction

  task automatic compare_and_step();
    bit       io_card, sl, win, wr_now;
    logic [7:0] reg_val, e_zd, e_bd;
    io_card = !ziorq_n && is_card_port(za);
    sl      = io_card && (za[15:8] == 8'h80 || za[15:8] == 8'h7F);
    win     = ziorq_n && !zmreq_n && !zcsrom_n && m_wcfg[7] && (za[13:10] == m_wcfg[3:0]);
    case (za[15:8])
      8'h83:   reg_val = {m_ien_s, m_ien_w, m_run_s, m_run_w, 1'b0, usb_power, sl811_intrq, !w5300_int_n};
      8'h82:   reg_val = m_wcfg;
      8'h81:   reg_val = {7'b0, m_ms};
      default: reg_val = tb_bd;
    endcase
    if (!zrd_n)      e_zd = io_card ? reg_val : (win ? tb_bd : 8'hFF);
    else if (!zwr_n) e_zd = tb_zd;
    else             e_zd = 8'hFF;
    if (!zwr_n && (sl || win)) e_bd = tb_zd;
    else if (!zrd_n)           e_bd = tb_bd;
    else                       e_bd = 8'hFF;

    check("zd", zd, e_zd);
    check("bd", bd, e_bd);
    check("ziorqge", ziorqge, io_card && !zrd_n);
    check("zblkrom", zblkrom, !zcsrom_n && m_wcfg[7]);
    check("brd_n", brd_n, (sl || win) ? zrd_n : 1'b1);
    check("bwr_n", bwr_n, (sl || win) ? zwr_n : 1'b1);
    check("w5300_cs_n", w5300_cs_n, !win);
    check("w5300_addr", w5300_addr, win ? za[9:0] : 10'h0);
    check("sl811_cs_n", sl811_cs_n, !sl);
    check("sl811_a0", sl811_a0, sl && za[15:8] == 8'h7F);
    check("w5300_rst_n", w5300_rst_n, m_run_w);
    check("sl811_rst_n", sl811_rst_n, m_run_s);
    check("sl811_ms_n", sl811_ms_n, !m_ms);
    check("zint_n", zint_n,
          (INT_EN && ((m_ien_w && !w5300_int_n) || (m_ien_s && sl811_intrq))) ? 1'b0 : 1'b1);

    // A held write strobe counts once, on its first cycle.
    wr_now = io_card && !zwr_n;
    if (rst) begin
      {m_run_w, m_run_s, m_ien_w, m_ien_s} = 4'b0;
      m_wcfg = 8'h00; m_ms = 1'b1; m_prev_wr = 1'b0;
    end else begin
      if (wr_now && !m_prev_wr) begin
        case (za[15:8])
          8'h83: begin
            m_run_w = tb_zd[4]; m_run_s = tb_zd[5];
            m_ien_w = INT_EN && tb_zd[6]; m_ien_s = INT_EN && tb_zd[7];
          end
          8'h82:   m_wcfg = tb_zd;
          8'h81:   m_ms = tb_zd[0];
          default: ;
        endcase
      end
      m_prev_wr = wr_now;
    end
  endtask

  task automatic apply(input bit r, input logic [15:0] a, input bit iorq_n, input bit mreq_n,
                       input bit rd_n, input bit wr_n, input bit csrom_n,
                       input logic [7:0] wd, input logic [7:0] bdv);
    @(posedge clk); #1;
    rst = r; za = a; ziorq_n = iorq_n; zmreq_n = mreq_n; zrd_n = rd_n; zwr_n = wr_n;
    zcsrom_n = csrom_n; tb_zd = wd; tb_bd = bdv;
    tb_zd_oe = !wr_n;
    tb_bd_oe = !rd_n;
    @(negedge clk);
    compare_and_step();
  endtask

  task automatic idle();                        apply(0, 16'h0000, 1, 1, 1, 1, 1, 8'h00, 8'h00); endtask
  task automatic io_rd(input logic [15:0] a, input logic [7:0] b); apply(0, a, 0, 1, 0, 1, 1, 8'h00, b); endtask
  task automatic io_wr(input logic [15:0] a, input logic [7:0] d); apply(0, a, 0, 1, 1, 0, 1, d, 8'h00); endtask

  initial begin
    logic [7:0]  hi_tab [5] = '{8'h83, 8'h82, 8'h81, 8'h80, 8'h7F};
    logic [15:0] a;
    bit          r, iorq_n, mreq_n, rd_n, wr_n, csrom_n;
    int          kind, len;

    rst = 1'b1; za = 16'h0; ziorq_n = 1; zmreq_n = 1; zrd_n = 1; zwr_n = 1; zcsrom_n = 1;
    tb_zd_oe = 0; tb_bd_oe = 0; tb_zd = 8'h00; tb_bd = 8'h00;
    w5300_int_n = 1; sl811_intrq = 0; usb_power = 0;
    repeat (2) @(posedge clk);
    apply(1, 16'h0000, 1, 1, 1, 1, 1, 8'h00, 8'h00);

    idle();
    check("rst w5300_rst_n", w5300_rst_n, 1'b0);
    check("rst sl811_rst_n", sl811_rst_n, 1'b0);
    check("rst sl811_ms_n", sl811_ms_n, 1'b0);
    io_rd(16'h83AB, 8'h00);
    check("rd rstint", zd, 8'h00);
    check("rd rstint ziorqge", ziorqge, 1'b1);
    idle();

    io_wr(16'h83AB, 8'h30);
    idle();
    check("run w5300_rst_n", w5300_rst_n, 1'b1);
    check("run sl811_rst_n", sl811_rst_n, 1'b1);
    io_rd(16'h83AB, 8'h00);
    check("rd rstint run", zd, 8'h30);
    idle();

    io_wr(16'h80AB, 8'h05);
    check("sl addr cs_n", sl811_cs_n, 1'b0);
    check("sl addr a0", sl811_a0, 1'b0);
    check("sl addr bwr_n", bwr_n, 1'b0);
    check("sl addr bd", bd, 8'h05);
    idle();
    io_rd(16'h7FAB, 8'h5A);
    check("sl data zd", zd, 8'h5A);
    check("sl data a0", sl811_a0, 1'b1);
    check("sl data cs_n", sl811_cs_n, 1'b0);
    idle();

    io_wr(16'h82AB, 8'h82);
    idle();
    apply(0, 16'h0B12, 1, 0, 0, 1, 0, 8'h00, 8'hC3);
    check("win cs_n", w5300_cs_n, 1'b0);
    check("win addr", w5300_addr, 10'h312);
    check("win zblkrom", zblkrom, 1'b1);
    check("win zd", zd, 8'hC3);
    idle();

    w5300_int_n = 0;
    io_wr(16'h83AB, 8'h40);
    idle();
    check("irq set zint_n", zint_n, INT_EN ? 1'b0 : 1'b1);
    io_wr(16'h83AB, 8'h00);
    idle();
    check("irq clr zint_n", zint_n, 1'b1);
    w5300_int_n = 1;

    io_rd(16'h83AC, 8'h00);
    check("miss ziorqge", ziorqge, 1'b0);
    check("miss zd", zd, 8'hFF);
    check("miss cs_n", {w5300_cs_n, sl811_cs_n}, 2'b11);
    idle();

    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(0, 9);
      r    = ($urandom_range(0, 49) == 0);
      w5300_int_n = $urandom_range(0, 1);
      sl811_intrq = $urandom_range(0, 1);
      usb_power   = $urandom_range(0, 1);
      if (kind <= 6) begin
        a[15:8] = ($urandom_range(0, 5) == 5) ? 8'($urandom) : hi_tab[$urandom_range(0, 4)];
        a[7:0]  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : PORT_LO;
      end else begin
        a = 16'($urandom);
        if ($urandom_range(0, 1) == 1) a[13:10] = m_wcfg[3:0];
      end
      csrom_n = ($urandom_range(0, 3) == 0);
      iorq_n  = !(kind >= 1 && kind <= 6 || kind == 9);
      mreq_n  = !(kind >= 7);
      rd_n    = !(kind inside {1, 2, 3, 7, 9});
      wr_n    = !(kind inside {4, 5, 6, 8});
      len     = $urandom_range(1, 3);
      for (int c = 0; c < len; c++)
        apply(r, a, iorq_n, mreq_n, rd_n, wr_n, csrom_n, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
